// File: rtl/demux2_select_scheduler.sv
// demux2_select_scheduler
//   Produces the select token stream for a two-way stream demux. A job
//   sends count0 tokens of value 0 and then count1 tokens of value 1, and
//   repeats that for `rounds` rounds. One token is issued per demux item.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   cfg_count0   items per round routed to output 0
//   cfg_count1   items per round routed to output 1
//   cfg_rounds   number of rounds
//   cfg_valid    config valid
//   cfg_ready    config accepted on cfg_valid && cfg_ready (high only in IDLE)
//   select       token value (0 = out0, 1 = out1)
//   select_valid token valid
//   select_ready demux accepts the token
//   busy         job in progress (state != IDLE)
//   done         one-cycle pulse when a job completes
//
// All outputs are decoded from the state register, so there is no
// combinational path from any input to any output.
module demux2_select_scheduler #(
  parameter int unsigned COUNT_WIDTH  = 16,
  parameter int unsigned ROUNDS_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [COUNT_WIDTH-1:0]  cfg_count0,
  input  logic [COUNT_WIDTH-1:0]  cfg_count1,
  input  logic [ROUNDS_WIDTH-1:0] cfg_rounds,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  output logic                    select,
  output logic                    select_valid,
  input  logic                    select_ready,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH0  = 2'd1,
    PH1  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                  state_q;
  logic [COUNT_WIDTH-1:0]  count0_q;
  logic [COUNT_WIDTH-1:0]  count1_q;
  logic [COUNT_WIDTH-1:0]  rem_q;
  logic [ROUNDS_WIDTH-1:0] rounds_left_q;

  // Where the last handshake of a round leads. Computed once and shared by
  // PH0 (when count1 is zero) and PH1, so both round-end paths stay identical.
  state_t                  rend_state;
  logic [COUNT_WIDTH-1:0]  rend_rem;

  always_comb begin
    rend_state = DONE;
    rend_rem   = '0;
    if (rounds_left_q == ROUNDS_WIDTH'(1)) begin
      rend_state = DONE;
      rend_rem   = '0;
    end else if (count0_q != '0) begin
      rend_state = PH0;
      rend_rem   = count0_q;
    end else begin
      rend_state = PH1;
      rend_rem   = count1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      count0_q      <= '0;
      count1_q      <= '0;
      rem_q         <= '0;
      rounds_left_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_valid) begin
            count0_q      <= cfg_count0;
            count1_q      <= cfg_count1;
            rounds_left_q <= cfg_rounds;
            if (cfg_rounds == '0 || (cfg_count0 == '0 && cfg_count1 == '0)) begin
              state_q <= DONE;
              rem_q   <= '0;
            end else if (cfg_count0 != '0) begin
              state_q <= PH0;
              rem_q   <= cfg_count0;
            end else begin
              state_q <= PH1;
              rem_q   <= cfg_count1;
            end
          end
        end

        PH0: begin
          if (select_ready) begin
            if (rem_q == COUNT_WIDTH'(1)) begin
              if (count1_q != '0) begin
                state_q <= PH1;
                rem_q   <= count1_q;
              end else begin
                state_q <= rend_state;
                rem_q   <= rend_rem;
                if (rounds_left_q != '0) rounds_left_q <= rounds_left_q - ROUNDS_WIDTH'(1);
              end
            end else if (rem_q != '0) begin
              rem_q <= rem_q - COUNT_WIDTH'(1);
            end
          end
        end

        PH1: begin
          if (select_ready) begin
            if (rem_q == COUNT_WIDTH'(1)) begin
              state_q <= rend_state;
              rem_q   <= rend_rem;
              if (rounds_left_q != '0) rounds_left_q <= rounds_left_q - ROUNDS_WIDTH'(1);
            end else if (rem_q != '0) begin
              rem_q <= rem_q - COUNT_WIDTH'(1);
            end
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cfg_ready    = (state_q == IDLE);
  assign select_valid = (state_q == PH0) || (state_q == PH1);
  assign select       = (state_q == PH1);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);

endmodule

// File: tb/tb_demux2_select_scheduler.sv
// Scoreboard bench for demux2_select_scheduler. Stimulus pushes the
// hand-derived token sequence of each job into a queue; a negedge monitor
// compares every presented token against the queue head and pops on handshake.
module tb_demux2_select_scheduler;

  logic        clk;
  logic        rst;
  logic [15:0] cfg_count0;
  logic [15:0] cfg_count1;
  logic [7:0]  cfg_rounds;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        select;
  logic        select_valid;
  logic        select_ready;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int hs_cnt   = 0;
  logic rdy_toggle = 1'b0;
  bit exp_tok[$];

  demux2_select_scheduler #(
    .COUNT_WIDTH  (16),
    .ROUNDS_WIDTH (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_count0   (cfg_count0),
    .cfg_count1   (cfg_count1),
    .cfg_rounds   (cfg_rounds),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .select       (select),
    .select_valid (select_valid),
    .select_ready (select_ready),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Ready driver: constant 1, or alternating 1,0 every cycle.
  initial begin
    select_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_toggle) select_ready = ~select_ready;
      else            select_ready = 1'b1;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (select_valid) begin
        if (exp_tok.size() == 0) begin
          chk("unexpected_token", 32'(select_valid), 0);
        end else begin
          chk("token_value", 32'(select), 32'(exp_tok[0]));
          if (select_ready) begin
            void'(exp_tok.pop_front());
            hs_cnt++;
          end
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_no_valid", 32'(select_valid), 0);
      end
    end
  end

  task automatic push_job(input int c0, input int c1, input int r);
    if (!(r == 0 || (c0 == 0 && c1 == 0))) begin
      for (int k = 0; k < r; k++) begin
        for (int i = 0; i < c0; i++) exp_tok.push_back(1'b0);
        for (int i = 0; i < c1; i++) exp_tok.push_back(1'b1);
      end
    end
  endtask

  task automatic drive_cfg(input int c0, input int c1, input int r);
    cfg_count0 = 16'(c0);
    cfg_count1 = 16'(c1);
    cfg_rounds = 8'(r);
    cfg_valid  = 1'b1;
  endtask

  // Runs one job from IDLE and checks latency, busy, done and drain.
  task automatic run_job(input int c0, input int c1, input int r);
    int n, cyc, d0;
    logic all_busy, seen;
    n = (r == 0 || (c0 == 0 && c1 == 0)) ? 0 : r * (c0 + c1);
    push_job(c0, c1, r);
    d0 = done_cnt;
    @(posedge clk); #1;
    drive_cfg(c0, c1, r);
    @(negedge clk);
    chk("cfg_ready_idle", 32'(cfg_ready), 1);
    @(posedge clk); #1;
    cfg_valid  = 1'b0;
    cfg_count0 = 16'hA5A5;
    cfg_count1 = 16'h5A5A;
    cfg_rounds = 8'hFF;
    cyc = 0; all_busy = 1'b1; seen = 1'b0;
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
      else if (!busy) all_busy = 1'b0;
    end
    if (!seen) begin
      chk("done_timeout", 0, 1);
    end else begin
      if (!rdy_toggle) chk("done_latency", 32'(cyc), 32'(n + 1));
      chk("busy_during_job", 32'(all_busy), 1);
      chk("busy_at_done", 32'(busy), 1);
    end
    @(negedge clk);
    chk("cfg_ready_after_done", 32'(cfg_ready), 1);
    chk("busy_idle", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("done_once", 32'(done_cnt - d0), 1);
    chk("tokens_drained", 32'(exp_tok.size()), 0);
  endtask

  initial begin
    int d0, cyc, h0;
    rst = 1'b0;
    cfg_valid = 1'b0;
    cfg_count0 = '0;
    cfg_count1 = '0;
    cfg_rounds = '0;
    repeat (2) @(negedge clk);
    chk("rst_select_valid", 32'(select_valid), 0);
    chk("rst_select", 32'(select), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    @(posedge clk); #1;
    rst = 1'b1;

    // Full throughput: 0,0,0,1,1,0,0,0,1,1
    run_job(3, 2, 2);

    // Backpressure alternating 1,0: same tokens, exactly 10 handshakes
    rdy_toggle = 1'b1;
    h0 = hs_cnt;
    run_job(3, 2, 2);
    chk("hs_count_toggle", 32'(hs_cnt - h0), 10);
    rdy_toggle = 1'b0;

    // count0=0: twelve 1s
    run_job(0, 4, 3);

    // Zero-work jobs
    run_job(3, 2, 0);
    run_job(0, 0, 5);

    // Single-item phases and count1=0
    run_job(1, 1, 1);
    run_job(2, 0, 2);

    // Config held high while busy: second job accepted only after IDLE
    push_job(2, 1, 1);
    push_job(1, 2, 1);
    d0 = done_cnt;
    @(posedge clk); #1;
    drive_cfg(2, 1, 1);
    @(posedge clk); #1;
    drive_cfg(1, 2, 1);
    @(negedge clk);
    chk("cfg_ready_busy", 32'(cfg_ready), 0);
    cyc = 0;
    while (!cfg_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("second_cfg_wait", 32'(cfg_ready), 1);
    chk("first_done_before_second", 32'(done_cnt - d0), 1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    cyc = 0;
    while (done_cnt < d0 + 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    chk("held_cfg_dones", 32'(done_cnt - d0), 2);
    chk("held_cfg_drained", 32'(exp_tok.size()), 0);

    // Reset mid-job after 4 handshakes of 3/2/2
    push_job(3, 2, 2);
    h0 = hs_cnt;
    @(posedge clk); #1;
    drive_cfg(3, 2, 2);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    cyc = 0;
    while (hs_cnt < h0 + 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("pre_reset_hs", 32'(hs_cnt - h0), 4);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_tok.delete();
    d0 = done_cnt;
    @(negedge clk);
    chk("abort_select_valid", 32'(select_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_cfg_ready", 32'(cfg_ready), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 0);
    run_job(1, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
